alu_exec_stage_32bit: RTL and testbench

//  Execute stage sitting between regfile_32bit read ports and its write port.
//  - Accepts an operation, two operands (regfile rd1/rd2) and a destination register.
//  - Computes the result and drives the regfile write port (wa/wd/we) as one registered pulse.
//  - Most ops take 1 cycle; MUL is an iterative 32-cycle shift-add, back-pressured by valid/ready.

---
 rtl/alu_exec_stage_32bit.sv | 163 ++++++++++++++++
 tb/tb_alu_exec_stage_32bit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage_32bit.sv
// Execute stage between the regfile read ports and its write port.
// Single-cycle ALU ops produce one registered write pulse per accepted op;
// MUL runs as a 32-step shift-add iteration with in_ready held low meanwhile.
module alu_exec_stage_32bit #(
    parameter int RWIDTH = 6,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [RWIDTH-1:0] dst,
    output logic              we,
    output logic [RWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wd,
    output logic              zero,
    output logic              ovf,
    output logic              err
);

    localparam int SHW = $clog2(DWIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    // S_RST holds in_ready low for the cycle right after a reset edge.
    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    logic [1:0]        state;
    logic [DWIDTH-1:0] acc;
    logic [DWIDTH-1:0] a_sh;
    logic [DWIDTH-1:0] b_sh;
    logic [SHW-1:0]    cnt;
    logic [RWIDTH-1:0] mul_dst;

    logic [DWIDTH-1:0] alu_res;
    logic              alu_ovf;
    logic              illegal;
    logic [SHW-1:0]    shamt;
    logic [DWIDTH-1:0] mul_sum;

    assign in_ready = (state == S_IDLE);
    assign shamt    = b[SHW-1:0];

    // Single-cycle ALU result, overflow flag and illegal-opcode decode.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = a + b;
                alu_ovf = (a[DWIDTH-1] == b[DWIDTH-1]) && (alu_res[DWIDTH-1] != a[DWIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_ovf = (a[DWIDTH-1] != b[DWIDTH-1]) && (alu_res[DWIDTH-1] != a[DWIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(DWIDTH-1){1'b0}}, (a < b)};
            OP_MUL:  alu_res = '0;
            default: illegal = 1'b1;
        endcase
    end

    // Next accumulator value for one shift-add multiply step.
    always_comb begin
        mul_sum = acc;
        if (b_sh[0]) begin
            mul_sum = acc + a_sh;
        end
    end

    // Control FSM, multiply iteration and registered regfile write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RST;
            we      <= 1'b0;
            err     <= 1'b0;
            wa      <= '0;
            wd      <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            acc     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            mul_dst <= '0;
        end else begin
            case (state)
                S_RST: begin
                    we    <= 1'b0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    we  <= 1'b0;
                    err <= 1'b0;
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            a_sh    <= a;
                            b_sh    <= b;
                            mul_dst <= dst;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= S_MUL;
                        end else if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            we   <= 1'b1;
                            wa   <= dst;
                            wd   <= alu_res;
                            zero <= (alu_res == '0);
                            ovf  <= alu_ovf;
                        end
                    end
                end
                S_MUL: begin
                    we   <= 1'b0;
                    err  <= 1'b0;
                    acc  <= mul_sum;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == SHW'(DWIDTH - 1)) begin
                        we    <= 1'b1;
                        wa    <= mul_dst;
                        wd    <= mul_sum;
                        zero  <= (mul_sum == '0);
                        ovf   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    we    <= 1'b0;
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage_32bit.sv
// Scoreboard bench for alu_exec_stage_32bit: directed cases plus randomized
// ops, expected writes computed by an arithmetic reference model.
module tb_alu_exec_stage_32bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [5:0]  dst = 6'd0;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        zero;
    logic        ovf;
    logic        err;

    typedef struct {
        bit          isErr;
        logic [5:0]  wa;
        logic [31:0] wd;
        bit          zero;
        bit          ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        monExp;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] rf [64];
    bit          preload = 1'b0;

    alu_exec_stage_32bit #(.RWIDTH(6), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .dst(dst),
        .we(we), .wa(wa), .wd(wd), .zero(zero), .ovf(ovf), .err(err)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tiny regfile model fed by the DUT write port.
    always @(posedge clk) begin
        if (preload) rf[5] <= 32'hAAAAAAAA;
        else if (we === 1'b1) rf[wa] <= wd;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: results straight from the opcode definitions.
    function automatic void refModel(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] res, output bit ov, output bit ill);
        logic [32:0] s;
        logic [63:0] p;
        int          sh;
        sh  = int'(y[4:0]);
        res = 32'd0;
        ov  = 1'b0;
        ill = 1'b0;
        case (o)
            4'd0: begin s = {x[31], x} + {y[31], y}; res = s[31:0]; ov = (s[32] != s[31]); end
            4'd1: begin s = {x[31], x} - {y[31], y}; res = s[31:0]; ov = (s[32] != s[31]); end
            4'd2: res = x & y;
            4'd3: res = x | y;
            4'd4: res = x ^ y;
            4'd5: res = x << sh;
            4'd6: res = x >> sh;
            4'd7: res = $unsigned($signed(x) >>> sh);
            4'd8: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9: res = (x < y) ? 32'd1 : 32'd0;
            4'd10: begin p = {32'd0, x} * {32'd0, y}; res = p[31:0]; end
            default: ill = 1'b1;
        endcase
    endfunction

    // Drive one op from a negedge, wait (bounded) for acceptance, queue the expectation.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [5:0] d, output int waited);
        exp_t        e;
        logic [31:0] r;
        bit          ov;
        bit          ill;
        in_valid = 1'b1;
        op  = o;
        a   = x;
        b   = y;
        dst = d;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready %b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        refModel(o, x, y, r, ov, ill);
        e.isErr = ill;
        e.wa    = d;
        e.wd    = r;
        e.zero  = (r == 32'd0);
        e.ovf   = ov;
        e.cyc   = cyc + 1 + ((o == 4'd10) ? 32 : 0);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d writes outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 6))
            0: return 32'h00000000;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every write or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (we === 1'b1 || err === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: we=%b err=%b wa=%0d wd=%0h, required no pulse", we, err, wa, wd);
            end else begin
                monExp = sb.pop_front();
                checkOutput("err", 32'(err), 32'(monExp.isErr));
                checkOutput("we", 32'(we), 32'(!monExp.isErr));
                checkOutput("latency_cycle", 32'(cyc), 32'(monExp.cyc));
                if (!monExp.isErr) begin
                    checkOutput("wa", 32'(wa), 32'(monExp.wa));
                    checkOutput("wd", wd, monExp.wd);
                    checkOutput("zero", 32'(zero), 32'(monExp.zero));
                    checkOutput("ovf", 32'(ovf), 32'(monExp.ovf));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed cases followed by randomized traffic.
    initial begin
        int w;
        int r;
        logic [3:0] o;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_we", 32'(we), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_wd", wd, 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

        $display("[TB] back-to-back ADD/SUB");
        applyStimulus(4'd0, 32'h7FFFFFFF, 32'h00000001, 6'd12, w);
        applyStimulus(4'd1, 32'h00000005, 32'h00000005, 6'd63, w);
        checkOutput("back_to_back_wait", 32'(w), 32'd0);
        drain();

        $display("[TB] shifts and compares");
        applyStimulus(4'd7, 32'h80000000, 32'h00000004, 6'd1, w);
        applyStimulus(4'd6, 32'h80000000, 32'h00000004, 6'd2, w);
        applyStimulus(4'd8, 32'hFFFFFFFF, 32'h00000001, 6'd3, w);
        applyStimulus(4'd9, 32'hFFFFFFFF, 32'h00000001, 6'd4, w);
        drain();

        $display("[TB] MUL with held in_valid");
        applyStimulus(4'd10, 32'h0000FFFF, 32'h00010001, 6'd41, w);
        applyStimulus(4'd0, 32'h12345678, 32'h11111111, 6'd9, w);
        checkOutput("mul_busy_cycles", 32'(w), 32'd32);
        applyStimulus(4'd10, 32'hFFFFFFFF, 32'h00000002, 6'd42, w);
        drain();

        $display("[TB] reset during MUL");
        applyStimulus(4'd10, 32'h00001234, 32'h00005678, 6'd20, w);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("mul_abort_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mul_abort_we", 32'(we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mul_abort_ready_again", 32'(in_ready), 32'd1);
        applyStimulus(4'd0, 32'h00000001, 32'h00000002, 6'd7, w);
        repeat (40) @(negedge clk);
        drain();

        $display("[TB] illegal opcode");
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        applyStimulus(4'd13, 32'hDEADBEEF, 32'h00000001, 6'd5, w);
        checkOutput("illegal_in_ready", 32'(in_ready), 32'd1);
        drain();
        checkOutput("r5_unchanged", rf[5], 32'hAAAAAAAA);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) o = 4'd10;
            else if (r < 12) o = 4'($urandom_range(11, 15));
            else o = 4'($urandom_range(0, 9));
            applyStimulus(o, pickVal(), pickVal(), 6'($urandom_range(0, 63)), w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
